scatter_dispatch: RTL and testbench
===================================

SCATTER_DISPATCH -- requirements
Module: scatter_dispatch

Interface
REQ-001 SHALL have parameter LANES, default 16, the number of int8 lanes per beat.
REQ-002 SHALL have parameter DW, default 8, the lane width in bits.
REQ-003 SHALL have parameter NCL, default 4, the number of PE clusters served.
REQ-004 SHALL have port clk  input  1  the single clock; all state SHALL be on posedge clk.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mode_bcast  input  1  1 selects broadcast, 0 selects round-robin unicast; sampled at frame start only.
REQ-007 SHALL have port in_valid  input  1  upstream beat valid.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data  input  LANES*DW  packed signed lanes, lane 0 in the LSBs.
REQ-010 SHALL have port in_last  input  1  marks the final beat of a frame.
REQ-011 SHALL have port out_valid  output  NCL  per-cluster valid.
REQ-012 SHALL have port out_ready  input  NCL  per-cluster ready.
REQ-013 SHALL have port out_data  output  NCL*LANES*DW  cluster k occupies slice k.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a frame has fully drained.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, UNI, BC and DRAIN.
REQ-017 IDLE: in_ready=0; when in_valid=1, the next state SHALL be BC if mode_bcast=1, else UNI; ptr SHALL be 0.
REQ-018 Each cluster k SHALL hold a one-entry output register; free_k = !out_valid[k] || out_ready[k].
REQ-019 UNI: in_ready = free_ptr; an accepted beat SHALL load cluster ptr (out_valid[ptr]=1 the next cycle), and ptr SHALL advance mod NCL.
REQ-020 BC: in_ready = AND of free_k over all k; an accepted beat SHALL load all NCL clusters in the same cycle.
REQ-021 Latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-022 Full throughput: back-to-back beats SHALL be accepted when the target cluster(s) are ready.
REQ-023 out_valid[k] SHALL clear on out_valid[k] && out_ready[k] unless reloaded in the same cycle; a simultaneous pop and load SHALL keep it high with the new data.
REQ-024 out_data[k] SHALL hold stable while out_valid[k] && !out_ready[k].
REQ-025 An accepted beat with in_last=1 SHALL move UNI/BC to DRAIN; in_ready=0 in DRAIN.
REQ-026 DRAIN: when out_valid is all-zero, frame_done SHALL pulse for 1 cycle, the state SHALL return to IDLE and ptr SHALL reset to 0.
REQ-027 mode_bcast changes mid-frame SHALL be ignored.
REQ-028 Data SHALL pass bit-exact; there is no arithmetic.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, ptr=0, out_valid=0, out_data=0, in_ready=0, frame_done=0 and busy=0.
REQ-030 Reset mid-frame SHALL discard all held beats; no frame_done SHALL be produced for the aborted frame.

Structure
REQ-031 The state encoding and default LANES/DW/NCL SHALL live in the shared accelerator package.
REQ-032 The per-cluster output register SHALL be one sub-module, dispatch_slot, instantiated NCL times.

Verification
REQ-033 Unicast with 8 beats (lane0 = 0x01..0x08, last on beat 8) and all ready: clusters 0-3 SHALL receive beats 1,5 / 2,6 / 3,7 / 4,8; frame_done SHALL fire once, 2 cycles after out_valid clears.
REQ-034 Broadcast with 1 beat of 0x7F in every lane: all 4 clusters SHALL present 0x7F one cycle after acceptance.
REQ-035 Unicast with out_ready[2]=0 for 10 cycles: in_ready SHALL drop when ptr=2, data SHALL stay stable, and streaming SHALL resume on release.
REQ-036 Broadcast with out_ready=4'b1110: in_ready SHALL stay 0 until bit 0 rises.
REQ-037 rst asserted mid-frame after 3 beats: out_valid SHALL be 0 immediately, and a new frame SHALL start at cluster 0.
REQ-038 Simultaneous pop and reload on cluster 0 in broadcast mode: out_valid[0] SHALL stay 1 with the new data.

Source files
------------

// File: rtl/scatter_dispatch_pkg.sv
// Shared accelerator package: default beat geometry and dispatcher state encoding.
package scatter_dispatch_pkg;

   localparam int DEF_LANES = 16;
   localparam int DEF_DW    = 8;
   localparam int DEF_NCL   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_UNI   = 2'd1,
      ST_BC    = 2'd2,
      ST_DRAIN = 2'd3
   } disp_state_e;

   // Pointer width that stays legal for a single-cluster build.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scatter_dispatch_slot.sv
// One-entry output register for a single PE cluster; accepts a load whenever it is free.
module dispatch_slot #(
   parameter int BW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [BW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [BW-1:0] out_data,
   output logic          free
);

   assign free = !out_valid || out_ready;

   // A load wins over a pop, so pop+reload in one cycle keeps valid high with new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/scatter_dispatch.sv
// Frame dispatcher: spreads upstream beats round-robin (unicast) or to every cluster (broadcast).
module scatter_dispatch
   import scatter_dispatch_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DW    = DEF_DW,
   parameter int NCL   = DEF_NCL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode_bcast,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DW-1:0]     in_data,
   input  logic                    in_last,
   output logic [NCL-1:0]          out_valid,
   input  logic [NCL-1:0]          out_ready,
   output logic [NCL*LANES*DW-1:0] out_data,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int BW = LANES * DW;
   localparam int PW = ptr_w(NCL);

   disp_state_e    state, state_nxt;
   logic [PW-1:0]  ptr, ptr_nxt;
   logic           done_nxt;
   logic           accept;
   logic [NCL-1:0] free;
   logic [NCL-1:0] load;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         ST_UNI:  in_ready = free[ptr];
         ST_BC:   in_ready = &free;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign busy   = (state != ST_IDLE);

   // Mode is latched by the IDLE exit choice; later mode_bcast edges never reach the state.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            ptr_nxt = '0;
            if (in_valid) state_nxt = mode_bcast ? ST_BC : ST_UNI;
         end
         ST_UNI: begin
            if (accept) begin
               ptr_nxt = (ptr == PW'(NCL-1)) ? '0 : ptr + PW'(1);
               if (in_last) state_nxt = ST_DRAIN;
            end
         end
         ST_BC: begin
            if (accept && in_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_valid == '0) begin
               state_nxt = ST_IDLE;
               ptr_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         frame_done <= done_nxt;
      end
   end

   genvar k;
   generate
      for (k = 0; k < NCL; k++) begin : g_slot
         assign load[k] = accept && ((state == ST_BC) ||
                                     ((state == ST_UNI) && (ptr == PW'(k))));

         dispatch_slot #(.BW(BW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*BW +: BW]),
            .free      (free[k])
         );
      end
   endgenerate

endmodule

// File: tb/tb_scatter_dispatch.sv
// Self-checking bench for scatter_dispatch: directed frames plus random traffic vs a beat-level model.
module tb_scatter_dispatch;

   localparam int LANES = 16;
   localparam int DW    = 8;
   localparam int NCL   = 4;
   localparam int BW    = LANES * DW;
   localparam int MW    = NCL * BW;
   localparam logic [MW-1:0] ALL7F = {NCL*LANES{8'h7F}};

   logic              clk = 1'b0;
   logic              rst;
   logic              mode_bcast;
   logic              in_valid;
   logic              in_ready;
   logic [BW-1:0]     in_data;
   logic              in_last;
   logic [NCL-1:0]    out_valid;
   logic [NCL-1:0]    out_ready;
   logic [MW-1:0]     out_data;
   logic              frame_done;
   logic              busy;

   scatter_dispatch #(.LANES(LANES), .DW(DW), .NCL(NCL)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_bcast (mode_bcast),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Beat-level reference: each cluster holds at most one unconsumed beat.
   bit            held_v [NCL];
   logic [BW-1:0] held_d [NCL];
   int            phase;      // 0 idle, 1 streaming, 2 waiting for drain
   bit            md;         // frame mode captured at frame start
   int            bidx;       // beats accepted so far in this frame
   bit            exp_done;
   bit            last_acc;
   bit            chk7f;
   logic [7:0]    pop_log [NCL][16];
   int            pop_n [NCL];
   int            done_cnt, done_c, last_hold;

   task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit any_held();
      bit a = 0;
      for (int k = 0; k < NCL; k++) a |= held_v[k];
      return a;
   endfunction

   function automatic bit exp_rdy();
      bit r;
      if (phase != 1) return 1'b0;
      if (!md) return !held_v[bidx % NCL] || out_ready[bidx % NCL];
      r = 1'b1;
      for (int k = 0; k < NCL; k++) r &= (!held_v[k] || out_ready[k]);
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NCL; k++) begin held_v[k] = 0; held_d[k] = '0; end
      phase = 0; md = 0; bidx = 0; exp_done = 0; last_acc = 0;
   endtask

   task automatic check_outputs();
      logic [NCL-1:0] ev;
      for (int k = 0; k < NCL; k++) ev[k] = held_v[k];
      chk("out_valid", MW'(out_valid), MW'(ev));
      for (int k = 0; k < NCL; k++)
         if (held_v[k]) chk("out_data", MW'(out_data[k*BW +: BW]), MW'(held_d[k]));
      chk("in_ready", MW'(in_ready), MW'(exp_rdy()));
      chk("busy", MW'(busy), MW'(phase != 0));
      chk("frame_done", MW'(frame_done), MW'(exp_done));
   endtask

   // Advance the model across the coming clock edge using the inputs now applied.
   task automatic model_edge();
      bit acc, none;
      int tgt;
      acc  = in_valid && exp_rdy();
      tgt  = bidx % NCL;
      none = !any_held();
      exp_done = (phase == 2) && none;
      for (int k = 0; k < NCL; k++) begin
         if (held_v[k] && out_ready[k]) begin
            held_v[k] = 0;
            if (pop_n[k] < 16) begin
               pop_log[k][pop_n[k]] = held_d[k][7:0];
               pop_n[k]++;
            end
         end
         if (acc && (md || k == tgt)) begin
            held_v[k] = 1;
            held_d[k] = in_data;
         end
      end
      case (phase)
         0: if (in_valid) begin phase = 1; md = mode_bcast; bidx = 0; end
         1: if (acc && in_last) phase = 2;
         2: if (none) phase = 0;
         default: phase = 0;
      endcase
      if (acc) bidx++;
      last_acc = acc;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", MW'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_in_ready", MW'(in_ready), '0);
      chk("rst_busy", MW'(busy), '0);
      chk("rst_frame_done", MW'(frame_done), '0);
      model_clear();
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // rmode: 0 all ready, 1 random, 2 cluster 2 stalled 10 cycles, 3 cluster 0 stalled 8 cycles
   task automatic run_frame(input bit bc, input int n, input int rmode, input int abort_at);
      logic [BW-1:0] beats [16];
      int bi = 0;
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < LANES; l++) beats[i][l*DW +: DW] = chk7f ? 8'h7F : DW'($urandom);
         if (!chk7f) beats[i][7:0] = 8'(i + 1);
      end
      for (int k = 0; k < NCL; k++) pop_n[k] = 0;
      done_cnt = 0; done_c = -1; last_hold = -1; last_acc = 0;
      for (int c = 0; c < 400; c++) begin
         case (rmode)
            0: out_ready = '1;
            1: out_ready = NCL'($urandom) | NCL'($urandom);
            2: out_ready = (c < 10) ? ~NCL'(4) : '1;
            default: out_ready = (c < 8) ? ~NCL'(1) : '1;
         endcase
         mode_bcast = (c == 0) ? bc : 1'($urandom);
         in_valid   = (bi < n) && (rmode != 1 || ($urandom % 4) != 0);
         in_data    = beats[(bi < n) ? bi : 0];
         in_last    = (bi == n - 1);
         #1;
         if (any_held()) last_hold = c;
         if (frame_done) begin done_cnt++; done_c = c; end
         if (chk7f && last_acc) begin
            chk("bc7f_valid", MW'(out_valid), MW'({NCL{1'b1}}));
            chk("bc7f_data", out_data, ALL7F);
         end
         check_outputs();
         model_edge();
         if (last_acc) bi++;
         @(posedge clk); #1;
         if (abort_at > 0 && bi == abort_at) begin
            do_reset();
            return;
         end
         if (done_c >= 0) break;
      end
      in_valid = 1'b0;
      chk("frame_completes", MW'(done_c >= 0), MW'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; mode_bcast = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = '1;
      chk7f = 0;
      model_clear();
      @(posedge clk); #1;
      do_reset();

      // Unicast 8 beats, everything ready: round-robin order and done timing.
      run_frame(1'b0, 8, 0, 0);
      for (int k = 0; k < NCL; k++)
         chk("uni_order", MW'({pop_log[k][0], pop_log[k][1]}), MW'({8'(k + 1), 8'(k + 5)}));
      chk("uni_done_once", MW'(done_cnt), MW'(1));
      chk("uni_done_lat", MW'(done_c - last_hold), MW'(2));

      // Broadcast single 0x7F beat.
      chk7f = 1;
      run_frame(1'b1, 1, 0, 0);
      chk7f = 0;

      // Unicast with cluster 2 stalled, then broadcast with cluster 0 stalled.
      run_frame(1'b0, 12, 2, 0);
      chk("stall2_order", MW'({pop_log[2][0], pop_log[2][1], pop_log[2][2]}), MW'({8'd3, 8'd7, 8'd11}));
      run_frame(1'b1, 3, 3, 0);
      chk("stall0_bc_pops", MW'(pop_n[0]), MW'(3));

      // Reset after 3 accepted beats, then a fresh frame must start at cluster 0.
      run_frame(1'b0, 8, 0, 3);
      run_frame(1'b0, 4, 0, 0);
      chk("post_rst_c0", MW'(pop_log[0][0]), MW'(8'd1));
      chk("post_rst_c3", MW'(pop_log[3][0]), MW'(8'd4));

      // Broadcast back-to-back with all ready: cluster 0 pops and reloads each cycle.
      run_frame(1'b1, 4, 0, 0);
      chk("bc_reload_order", MW'({pop_log[0][0], pop_log[0][1], pop_log[0][2], pop_log[0][3]}),
          MW'({8'd1, 8'd2, 8'd3, 8'd4}));

      // Random traffic and random mode_bcast toggling.
      for (int i = 0; i < 8; i++) run_frame(1'($urandom), 1 + int'($urandom % 10), 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
